lvt_accounter: RTL and testbench

Parametrised live-value table for the multi-port RAM. It tracks which write agent last wrote each row and tells every read agent which bank to select. It adds four things to the per-reader accounter:
- a single shared table for all readers;
- deterministic priority when several writers hit the same row;
- configurable read latency and read-during-write behaviour;
- a hardware clear sequencer.

It sits between the agent ports and the output muxes of the replicated RAM banks.

---
 rtl/meduram_pkg.sv | 17 +
 rtl/lvt_rdport.sv | 74 +++++++
 rtl/lvt_accounter.sv | 131 +++++++++++++
 tb/tb_lvt_accounter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/meduram_pkg.sv
// Shared types and helpers for the multi-port RAM live-value table.
package meduram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } lvt_state_e;

  localparam int unsigned RD_LATENCY_MIN = 1;
  localparam int unsigned RD_LATENCY_MAX = 2;

  // Width needed to index n items; never below one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lvt_rdport.sv
// One read agent of the live-value table: range check, lookup, write bypass
// and an RD_LATENCY-deep valid/select pipeline.
module lvt_rdport
  import meduram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned RAM_DEPTH    = 256,
  parameter int unsigned NB_WRAGENT   = 2,
  parameter int unsigned SELECT_WIDTH = 1,
  parameter int unsigned RD_LATENCY   = 1,
  parameter bit          RW_BYPASS    = 1'b0
) (
  input  logic                                 aclk,
  input  logic                                 srst,
  input  logic                                 i_rden,
  input  logic [ADDR_WIDTH-1:0]                i_rdaddr,
  input  logic [RAM_DEPTH-1:0][SELECT_WIDTH-1:0] i_table,
  input  logic [NB_WRAGENT-1:0]                i_wr_acc,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0]     i_wraddr,
  output logic                                 o_rdvalid,
  output logic [SELECT_WIDTH-1:0]              o_rdselect
);

  localparam int unsigned IDX_W = sel_width(RAM_DEPTH);
  localparam int unsigned AW1   = ADDR_WIDTH + 1;

  logic                    w_in_range;
  logic [IDX_W-1:0]        w_idx;
  logic [SELECT_WIDTH-1:0] w_stored;
  logic                    w_bypass_hit;
  logic [SELECT_WIDTH-1:0] w_bypass_sel;
  logic [SELECT_WIDTH-1:0] w_sel;

  logic [RD_LATENCY-1:0]                   r_vld;
  logic [RD_LATENCY-1:0][SELECT_WIDTH-1:0] r_sel;

  // Out-of-range rows read as owner 0; the truncated index is masked then.
  assign w_in_range = {1'b0, i_rdaddr} < AW1'(RAM_DEPTH);
  assign w_idx      = IDX_W'(i_rdaddr);
  assign w_stored   = w_in_range ? i_table[w_idx] : '0;

  // Accepted writes arrive pre-resolved; scanning upward leaves the highest index.
  always_comb begin
    w_bypass_hit = 1'b0;
    w_bypass_sel = '0;
    for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
      if (i_wr_acc[i] && (i_wraddr[ADDR_WIDTH*i +: ADDR_WIDTH] == i_rdaddr)) begin
        w_bypass_hit = 1'b1;
        w_bypass_sel = SELECT_WIDTH'(i);
      end
    end
  end

  assign w_sel = (RW_BYPASS && w_bypass_hit) ? w_bypass_sel : w_stored;

  // Select stages only load behind a valid so rdselect holds between reads.
  always_ff @(posedge aclk) begin
    if (srst) begin
      r_vld <= '0;
      r_sel <= '0;
    end else begin
      r_vld[0] <= i_rden;
      if (i_rden) r_sel[0] <= w_sel;
      for (int unsigned s = 1; s < RD_LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) r_sel[s] <= r_sel[s-1];
      end
    end
  end

  assign o_rdvalid  = r_vld[RD_LATENCY-1];
  assign o_rdselect = r_sel[RD_LATENCY-1];

endmodule

// File: rtl/lvt_accounter.sv
// Shared live-value table: records the last write agent per row, clears
// itself after reset/flush, and feeds one lvt_rdport per read agent.
module lvt_accounter
  import meduram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned RAM_DEPTH    = 2**ADDR_WIDTH,
  parameter int unsigned NB_WRAGENT   = 2,
  parameter int unsigned NB_RDAGENT   = 2,
  parameter int unsigned SELECT_WIDTH = sel_width(NB_WRAGENT),
  parameter int unsigned RD_LATENCY   = 1,
  parameter bit          RW_BYPASS    = 1'b0
) (
  input  logic                               aclk,
  input  logic                               srst,
  input  logic                               flush,
  output logic                               ready,
  input  logic [NB_WRAGENT-1:0]              wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0]   wraddr,
  input  logic [NB_RDAGENT-1:0]              rden,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   rdaddr,
  output logic [NB_RDAGENT-1:0]              rdvalid,
  output logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect
);

  localparam int unsigned    IDX_W    = sel_width(RAM_DEPTH);
  localparam int unsigned    AW1      = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(RAM_DEPTH - 1);

  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("lvt_accounter: RD_LATENCY must be 1 or 2");
  end

  lvt_state_e       r_state;
  lvt_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_nxt;
  logic             w_ready;
  logic             w_clear_we;

  logic [RAM_DEPTH-1:0][SELECT_WIDTH-1:0] r_table;
  logic [NB_WRAGENT-1:0]                  w_wr_acc;
  logic [NB_RDAGENT-1:0]                  w_rd_acc;

  // State register and clear counter.
  always_ff @(posedge aclk) begin
    if (srst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: sweep every row once, then run until flushed.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      CLEAR: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        if (flush) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    w_ready    = 1'b0;
    w_clear_we = 1'b0;
    unique case (r_state)
      CLEAR: w_clear_we = 1'b1;
      RUN:   w_ready    = 1'b1;
    endcase
  end

  assign ready = w_ready;

  always_comb begin
    for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
      w_wr_acc[i] = w_ready && wren[i] &&
                    ({1'b0, wraddr[ADDR_WIDTH*i +: ADDR_WIDTH]} < AW1'(RAM_DEPTH));
    end
  end

  assign w_rd_acc = rden & {NB_RDAGENT{w_ready}};

  // Table update; later (higher-index) agents override earlier ones on a shared row.
  always_ff @(posedge aclk) begin
    if (w_clear_we) begin
      r_table[r_cnt] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
        if (w_wr_acc[i]) r_table[IDX_W'(wraddr[ADDR_WIDTH*i +: ADDR_WIDTH])] <= SELECT_WIDTH'(i);
      end
    end
  end

  for (genvar g = 0; g < NB_RDAGENT; g++) begin : g_rd
    lvt_rdport #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .RAM_DEPTH   (RAM_DEPTH),
      .NB_WRAGENT  (NB_WRAGENT),
      .SELECT_WIDTH(SELECT_WIDTH),
      .RD_LATENCY  (RD_LATENCY),
      .RW_BYPASS   (RW_BYPASS)
    ) u_rdport (
      .aclk      (aclk),
      .srst      (srst),
      .i_rden    (w_rd_acc[g]),
      .i_rdaddr  (rdaddr[ADDR_WIDTH*g +: ADDR_WIDTH]),
      .i_table   (r_table),
      .i_wr_acc  (w_wr_acc),
      .i_wraddr  (wraddr),
      .o_rdvalid (rdvalid[g]),
      .o_rdselect(rdselect[SELECT_WIDTH*g +: SELECT_WIDTH])
    );
  end

endmodule

// File: tb/tb_lvt_accounter.sv
// Directed bench for lvt_accounter: two configurations (latency 1 with bypass,
// latency 2 without) share one stimulus stream.
module tb_lvt_accounter;

  localparam int unsigned AW = 5;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NW = 3;
  localparam int unsigned NR = 2;
  localparam int unsigned SW = 2;

  logic aclk, srst, flush;
  logic [NW-1:0]    wren;
  logic [NW*AW-1:0] wraddr;
  logic [NR-1:0]    rden;
  logic [NR*AW-1:0] rdaddr;
  logic             a_ready, b_ready;
  logic [NR-1:0]    a_rdvalid, b_rdvalid;
  logic [NR*SW-1:0] a_rdselect, b_rdselect;

  int n_checks = 0;
  int n_err = 0;

  lvt_accounter #(.ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .NB_WRAGENT(NW), .NB_RDAGENT(NR),
                  .RD_LATENCY(1), .RW_BYPASS(1'b1)) dut_a (
    .aclk(aclk), .srst(srst), .flush(flush), .ready(a_ready),
    .wren(wren), .wraddr(wraddr), .rden(rden), .rdaddr(rdaddr),
    .rdvalid(a_rdvalid), .rdselect(a_rdselect));

  lvt_accounter #(.ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .NB_WRAGENT(NW), .NB_RDAGENT(NR),
                  .RD_LATENCY(2), .RW_BYPASS(1'b0)) dut_b (
    .aclk(aclk), .srst(srst), .flush(flush), .ready(b_ready),
    .wren(wren), .wraddr(wraddr), .rden(rden), .rdaddr(rdaddr),
    .rdvalid(b_rdvalid), .rdselect(b_rdselect));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [NW-1:0]    wren;
    logic [NW*AW-1:0] wraddr;
    logic [NR-1:0]    rden;
    logic [NR*AW-1:0] rdaddr;
    logic [NR*SW-1:0] sel_a;
    logic [NR*SW-1:0] sel_b;
  } vec_t;

  vec_t tab[19];

  function automatic vec_t mk(input logic [2:0] we, input int w0, input int w1, input int w2,
                              input logic [1:0] re, input int r0, input int r1,
                              input int a0, input int a1, input int b0, input int b1);
    vec_t v;
    v.wren   = we;
    v.wraddr = {AW'(w2), AW'(w1), AW'(w0)};
    v.rden   = re;
    v.rdaddr = {AW'(r1), AW'(r0)};
    v.sel_a  = {SW'(a1), SW'(a0)};
    v.sel_b  = {SW'(b1), SW'(b0)};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One vector: inputs for one cycle, then an idle cycle so both latencies land.
  task automatic apply_vec(input int idx);
    vec_t v;
    v = tab[idx];
    wren = v.wren; wraddr = v.wraddr; rden = v.rden; rdaddr = v.rdaddr;
    tick();
    wren = '0; rden = '0;
    chk($sformatf("v%0d a_rdvalid", idx), 32'(a_rdvalid), 32'(v.rden));
    chk($sformatf("v%0d a_rdselect", idx), 32'(a_rdselect), 32'(v.sel_a));
    chk($sformatf("v%0d b_rdvalid_early", idx), 32'(b_rdvalid), 32'(0));
    tick();
    chk($sformatf("v%0d b_rdvalid", idx), 32'(b_rdvalid), 32'(v.rden));
    chk($sformatf("v%0d b_rdselect", idx), 32'(b_rdselect), 32'(v.sel_b));
    chk($sformatf("v%0d a_rdvalid_idle", idx), 32'(a_rdvalid), 32'(0));
  endtask

  // Called right after the edge that starts a clear (srst released or flush taken).
  task automatic wait_clear(input string tag);
    for (int i = 0; i < int'(DEPTH); i++) begin
      chk($sformatf("%s a_ready_low[%0d]", tag, i), 32'(a_ready), 32'(0));
      chk($sformatf("%s b_ready_low[%0d]", tag, i), 32'(b_ready), 32'(0));
      chk($sformatf("%s rdvalid_in_clear[%0d]", tag, i), 32'({a_rdvalid, b_rdvalid}), 32'(0));
      tick();
    end
    chk($sformatf("%s a_ready_high", tag), 32'(a_ready), 32'(1));
    chk($sformatf("%s b_ready_high", tag), 32'(b_ready), 32'(1));
  endtask

  initial begin
    //           wren    w0 w1 w2  rden   r0 r1  a0 a1 b0 b1
    tab[0]  = mk(3'b000, 0, 0, 0,  2'b11, 0, 15, 0, 0, 0, 0);
    tab[1]  = mk(3'b010, 0, 5, 0,  2'b00, 0, 0,  0, 0, 0, 0);
    tab[2]  = mk(3'b000, 0, 0, 0,  2'b11, 5, 20, 1, 0, 1, 0);
    tab[3]  = mk(3'b111, 9, 9, 9,  2'b00, 0, 0,  1, 0, 1, 0);
    tab[4]  = mk(3'b000, 0, 0, 0,  2'b11, 9, 9,  2, 2, 2, 2);
    tab[5]  = mk(3'b011, 3, 4, 0,  2'b00, 0, 0,  2, 2, 2, 2);
    tab[6]  = mk(3'b000, 0, 0, 0,  2'b11, 3, 4,  0, 1, 0, 1);
    tab[7]  = mk(3'b001, 7, 0, 0,  2'b00, 0, 0,  0, 1, 0, 1);
    tab[8]  = mk(3'b010, 0, 7, 0,  2'b11, 4, 7,  1, 1, 1, 0);
    tab[9]  = mk(3'b000, 0, 0, 0,  2'b11, 7, 7,  1, 1, 1, 1);
    tab[10] = mk(3'b110, 0, 2, 20, 2'b01, 20, 0, 0, 1, 0, 1);
    tab[11] = mk(3'b010, 0, 3, 0,  2'b10, 0, 2,  0, 1, 0, 1);
    tab[12] = mk(3'b000, 0, 0, 0,  2'b11, 2, 3,  1, 1, 1, 1);
    tab[13] = mk(3'b101, 6, 0, 6,  2'b11, 6, 6,  2, 2, 0, 0);
    tab[14] = mk(3'b000, 0, 0, 0,  2'b11, 6, 6,  2, 2, 2, 2);
    tab[15] = mk(3'b000, 0, 0, 0,  2'b11, 2, 3,  0, 0, 0, 0);
    tab[16] = mk(3'b000, 0, 0, 0,  2'b11, 9, 5,  0, 0, 0, 0);
    tab[17] = mk(3'b100, 0, 0, 12, 2'b00, 0, 0,  0, 0, 0, 0);
    tab[18] = mk(3'b000, 0, 0, 0,  2'b11, 12, 4, 2, 0, 2, 0);

    srst = 1'b1; flush = 1'b0; wren = '0; wraddr = '0; rden = '0; rdaddr = '0;
    tick();
    chk("reset ready", 32'({a_ready, b_ready}), 32'(0));
    chk("reset rdvalid", 32'({a_rdvalid, b_rdvalid}), 32'(0));
    chk("reset rdselect", 32'({a_rdselect, b_rdselect}), 32'(0));
    tick();
    tick();
    srst = 1'b0;
    rden = 2'b11; rdaddr = {AW'(1), AW'(1)};
    wait_clear("init");
    rden = '0;

    for (int i = 0; i <= 14; i++) apply_vec(i);

    // Flush with a read in the same cycle: that read still returns the old owner.
    flush = 1'b1; rden = 2'b01; rdaddr = {AW'(0), AW'(2)};
    tick();
    flush = 1'b0; rden = '0;
    chk("flush a_ready_low[0]", 32'(a_ready), 32'(0));
    chk("flush preflush a_rdvalid", 32'(a_rdvalid), 32'(1));
    chk("flush preflush a_rdselect", 32'(a_rdselect), 32'({2'd2, 2'd1}));
    for (int i = 1; i <= int'(DEPTH); i++) begin
      flush = (i == 4);
      tick();
      if (i == 1) begin
        chk("flush preflush b_rdvalid", 32'(b_rdvalid), 32'(1));
        chk("flush preflush b_rdselect", 32'(b_rdselect), 32'({2'd2, 2'd1}));
      end
      chk($sformatf("flush a_ready[%0d]", i), 32'(a_ready), 32'(i == int'(DEPTH)));
      chk($sformatf("flush b_ready[%0d]", i), 32'(b_ready), 32'(i == int'(DEPTH)));
    end
    flush = 1'b0;

    for (int i = 15; i <= 18; i++) apply_vec(i);

    // srst while a latency-2 read is in flight, then srst again at clear row 6.
    rden = 2'b11; rdaddr = {AW'(12), AW'(12)};
    tick();
    rden = '0;
    chk("midrun a_rdvalid", 32'(a_rdvalid), 32'(3));
    chk("midrun a_rdselect", 32'(a_rdselect), 32'({2'd2, 2'd2}));
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("midrun srst b_rdvalid", 32'(b_rdvalid), 32'(0));
    chk("midrun srst rdselect", 32'({a_rdselect, b_rdselect}), 32'(0));
    chk("midrun srst ready", 32'({a_ready, b_ready}), 32'(0));
    rden = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("partial clear ready[%0d]", i), 32'({a_ready, b_ready}), 32'(0));
      chk($sformatf("partial clear rdvalid[%0d]", i), 32'({a_rdvalid, b_rdvalid}), 32'(0));
    end
    srst = 1'b1;
    tick();
    srst = 1'b0;
    wait_clear("midclear");
    rden = '0;

    apply_vec(15);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
